mc_control: RTL
===============

# mc_control

Multi-cycle control unit for the RV32I core: the sequential successor to the single-cycle opcode decoder. It holds a FETCH/DECODE/EXEC/MEM/WB/TRAP state machine and drives all datapath strobes. It runs a req/ready handshake to the unified memory port, adds load/store/illegal-opcode handling, and keeps a retired-instruction counter. It sits between the instruction register and the datapath/register-file enables.

## Interface
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT_CYCLES, 16, memory wait limit (used only with MC_CONTROL_TIMEOUT_EN)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- opcode  in  7  instruction[6:0] from instruction register, valid from DECODE onward
- mem_ready  in  1  memory accepts/completes current request
- mem_req  out  1  memory request (fetch or data)
- mem_we  out  1  store request qualifier
- ir_write  out  1  load instruction register (one cycle)
- pc_inc  out  1  PC <= PC+4 (one cycle)
- reg_write  out  1  register-file write enable
- imm_data  out  1  ALU operand B = immediate
- opcode_alu  out  2  ALU op class: 01 op_imm, 11 op, 10 branch, 00 add
- mem_to_reg  out  1  writeback data from memory
- branch  out  1  PC may load branch/jump target (datapath qualifies condition)
- wb_pc  out  1  writeback data = PC+4
- trap  out  1  sticky halt indicator
- trap_cause  out  2  00 none, 01 illegal opcode, 10 memory timeout
- instret  out  CNT_W  retired-instruction count

## Operation
- Opcode classes (opcode[6:2], opcode[1:0] must be 11): OP_IMM 00100, OP 01100, LOAD 00000, STORE 01000, BRANCH 11000, JAL 11011. Anything else is illegal.
- Class latched into a register in DECODE. Outputs are functions of state + latched class only; no input-to-output path except through state.
- FETCH: mem_req=1, mem_we=0. On mem_req&&mem_ready: ir_write=1, pc_inc=1 that cycle; next DECODE.
- DECODE: illegal -> TRAP (cause 01); otherwise EXEC.
- EXEC: opcode_alu/imm_data per class (imm_data=1 for OP_IMM/LOAD/STORE).
  - OP, OP_IMM, JAL -> WB.
  - LOAD, STORE -> MEM.
  - BRANCH: branch=1, opcode_alu=10; retire; -> FETCH.
- MEM: mem_req=1, mem_we=1 for STORE. On ready: STORE retires -> FETCH; LOAD -> WB.
- WB: reg_write=1 for one cycle. mem_to_reg=1 for LOAD. JAL: wb_pc=1 and branch=1. Retire; -> FETCH.
- TRAP: all strobes 0, no requests; stays until rst.
- instret increments by 1 on each retire; wraps modulo 2^CNT_W.
- Handshake: mem_req stays high, and mem_we stays stable, until a rising edge samples mem_ready=1. mem_ready with mem_req=0 is ignored.

## Timing
- Reset values: state FETCH, every output 0, instret 0, trap_cause 00. While rst is high, mem_req is forced 0. The first fetch request is in the first cycle after rst deasserts.
- rst mid-transaction: request drops asynchronously, state returns to FETCH, latched class cleared.
- Zero-wait latency (ready in the request cycle), in cycles per instruction: OP/OP_IMM/JAL 4, LOAD 5, STORE 4, BRANCH 3, illegal reaches TRAP after 2.
- Each wait cycle in FETCH/MEM adds 1 cycle.
- The ir_write/pc_inc and reg_write strobes are single-cycle pulses.

## Configuration
- MC_CONTROL_TIMEOUT_EN defined:
  - A wait counter clears on entering FETCH/MEM and counts cycles with mem_req&&!mem_ready.
  - Reaching TIMEOUT_CYCLES -> TRAP, cause 10, mem_req drops next cycle.
  - A ready that arrives in the same cycle the count is reached wins: the transfer completes and there is no trap.
- Undefined: no counter, wait is unbounded, and trap_cause never reads 10.

## Structure
- Shared package mc_pkg holds:
  - state enum
  - opcode class constants and 5-bit opcode values
  - opcode_alu encodings
  - trap_cause codes
- One sub-module, mc_decode: combinational opcode[6:0] -> class + illegal flag, reused by a future pipelined decode stage.

## Test plan
- After reset, feed OP (0110011) with mem_ready tied 1:
  - mem_req is high in cycle 0 and ir_write/pc_inc pulse in cycle 0.
  - reg_write=1, imm_data=0, opcode_alu=11 in cycle 3.
  - instret=1 in cycle 4.
- LOAD (0000011), fetch zero-wait, data ready delayed 3 cycles:
  - MEM holds mem_req=1, mem_we=0 for 4 cycles.
  - WB then asserts reg_write=1, mem_to_reg=1.
  - Total 8 cycles.
- STORE (0100011): mem_we=1 throughout MEM, reg_write never asserted, instret +1 on ready.
- Branch and jump:
  - BRANCH (1100011): branch=1 with opcode_alu=10 in cycle 2, next fetch in cycle 3.
  - JAL (1101111): WB asserts reg_write, wb_pc, branch together.
- Illegal opcode 0000000: trap=1, trap_cause=01, no further mem_req for 20 cycles.
- Reset and wrap:
  - Assert rst mid-MEM: mem_req drops the same cycle, instret=0.
  - With CNT_W=4, 16 retires wraps instret to 0.
  - With MC_CONTROL_TIMEOUT_EN and mem_ready held 0 for 16 cycles: trap_cause=10.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode-class, ALU-op and trap-cause encodings for the multi-cycle control unit
package mc_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [2:0] {C_NONE, C_OP_IMM, C_OP, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_ILLEGAL} cls_t;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_IMM    = 2'b01;
  localparam logic [1:0] ALU_BRANCH = 2'b10;
  localparam logic [1:0] ALU_OP     = 2'b11;
  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_TIMEOUT = 2'b10;
  function automatic logic [1:0] alu_of(cls_t c);
    return c == C_OP_IMM ? ALU_IMM : c == C_OP ? ALU_OP : c == C_BRANCH ? ALU_BRANCH : ALU_ADD;
  endfunction
endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode[6:0] -> instruction class and illegal flag
module mc_decode
  import mc_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_t       cls,
  output logic       illegal
);
  always_comb begin
    cls = opcode[1:0] != 2'b11     ? C_ILLEGAL :
          opcode[6:2] == OPC_OP_IMM ? C_OP_IMM :
          opcode[6:2] == OPC_OP     ? C_OP :
          opcode[6:2] == OPC_LOAD   ? C_LOAD :
          opcode[6:2] == OPC_STORE  ? C_STORE :
          opcode[6:2] == OPC_BRANCH ? C_BRANCH :
          opcode[6:2] == OPC_JAL    ? C_JAL : C_ILLEGAL;
    illegal = cls == C_ILLEGAL;
  end
endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle RV32I control FSM with memory handshake and retire counter.
// Define MC_CONTROL_TIMEOUT_EN to trap on memory waits reaching TIMEOUT_CYCLES.
module mc_control
  import mc_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             reg_write,
  output logic             imm_data,
  output logic [1:0]       opcode_alu,
  output logic             mem_to_reg,
  output logic             branch,
  output logic             wb_pc,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);
  state_t state;
  cls_t   cls, dec_cls;
  logic   dec_illegal, xfer, retire;

  mc_decode u_decode (.opcode(opcode), .cls(dec_cls), .illegal(dec_illegal));

  // Strobes decode from registered state and class; only the handshake and the IR/PC
  // load that must land on the accepting edge look at mem_ready / rst directly.
  always_comb begin
    mem_req    = !rst && (state == S_FETCH || state == S_MEM);
    xfer       = mem_req && mem_ready;
    mem_we     = state == S_MEM && cls == C_STORE;
    ir_write   = state == S_FETCH && xfer;
    pc_inc     = state == S_FETCH && xfer;
    reg_write  = state == S_WB;
    imm_data   = state == S_EXEC && (cls == C_OP_IMM || cls == C_LOAD || cls == C_STORE);
    opcode_alu = state == S_EXEC ? alu_of(cls) : ALU_ADD;
    mem_to_reg = state == S_WB && cls == C_LOAD;
    branch     = (state == S_EXEC && cls == C_BRANCH) || (state == S_WB && cls == C_JAL);
    wb_pc      = state == S_WB && cls == C_JAL;
    trap       = state == S_TRAP;
    retire     = (state == S_EXEC && cls == C_BRANCH) || (state == S_MEM && cls == C_STORE && xfer) || state == S_WB;
  end

`ifdef MC_CONTROL_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WC_W-1:0] wcnt;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      cls        <= C_NONE;
      trap_cause <= TC_NONE;
      instret    <= '0;
`ifdef MC_CONTROL_TIMEOUT_EN
      wcnt       <= '0;
`endif
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      case (state)
        S_FETCH: if (xfer) state <= S_DECODE;
        S_DECODE: begin
          cls <= dec_cls;
          state <= dec_illegal ? S_TRAP : S_EXEC;
          if (dec_illegal) trap_cause <= TC_ILLEGAL;
        end
        S_EXEC: state <= cls == C_BRANCH ? S_FETCH : (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
        S_MEM: if (xfer) state <= cls == C_STORE ? S_FETCH : S_WB;
        S_WB: state <= S_FETCH;
        default: state <= S_TRAP;
      endcase
`ifdef MC_CONTROL_TIMEOUT_EN
      // A ready in the limit cycle is a completed transfer, not a wait, so it never traps.
      if (mem_req && !mem_ready) begin
        wcnt <= wcnt + WC_W'(1);
        if (wcnt == WC_W'(TIMEOUT_CYCLES - 1)) begin
          state      <= S_TRAP;
          trap_cause <= TC_TIMEOUT;
        end
      end else begin
        wcnt <= '0;
      end
`endif
    end
  end
endmodule
